// File: rtl/dbg_trace_pkg.sv
// Shared types and constants for the debug trace arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dbg_trace_pkg;

  localparam int HART_ID_W = 2;
  localparam int MAX_HARTS = 4;

  // One trace record: a fetch event and a writeback event (136 bits).
  typedef struct packed {
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rddata;
    logic        reg_wren;
    logic [4:0]  reg_wraddr;
    logic [63:0] reg_wrdata;
  } trace_rec_t;

endpackage

// File: rtl/dbg_trace_arbiter_if.sv
// Trace bus: per-hart record inputs, sink ready, serialised dbg_* output and drop stats.
// Latency: n/a (wiring only). Backpressure: out_ready stalls the dbg_* stage.
// Ports: master = record sources + trace sink; slave = the arbiter.
interface dbg_trace_arbiter_if
  import dbg_trace_pkg::*;
#(
  parameter int NUM_HARTS  = 4,
  parameter int DROP_CNT_W = 16
);
  logic [NUM_HARTS-1:0]            in_valid;
  logic [NUM_HARTS-1:0]            in_fetch_req;
  logic [NUM_HARTS-1:0]            in_fetch_ack;
  logic [NUM_HARTS*32-1:0]         in_fetch_addr;
  logic [NUM_HARTS*32-1:0]         in_fetch_rddata;
  logic [NUM_HARTS-1:0]            in_reg_wren;
  logic [NUM_HARTS*5-1:0]          in_reg_wraddr;
  logic [NUM_HARTS*64-1:0]         in_reg_wrdata;
  logic                            out_ready;

  logic                            dbg_valid;
  logic [HART_ID_W-1:0]            dbg_hart_id;
  logic                            dbg_inst_fetch_req;
  logic                            dbg_inst_fetch_ack;
  logic                            dbg_reg_wren;
  logic [31:0]                     dbg_inst_fetch_addr;
  logic [31:0]                     dbg_inst_fetch_rddata;
  logic [4:0]                      dbg_reg_wraddr;
  logic [63:0]                     dbg_reg_wrdata;
  logic [NUM_HARTS-1:0]            overflow;
  logic [NUM_HARTS*DROP_CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_fetch_req, in_fetch_ack, in_fetch_addr, in_fetch_rddata,
           in_reg_wren, in_reg_wraddr, in_reg_wrdata, out_ready,
    input  dbg_valid, dbg_hart_id, dbg_inst_fetch_req, dbg_inst_fetch_ack, dbg_reg_wren,
           dbg_inst_fetch_addr, dbg_inst_fetch_rddata, dbg_reg_wraddr, dbg_reg_wrdata,
           overflow, drop_cnt
  );

  modport slave (
    input  in_valid, in_fetch_req, in_fetch_ack, in_fetch_addr, in_fetch_rddata,
           in_reg_wren, in_reg_wraddr, in_reg_wrdata, out_ready,
    output dbg_valid, dbg_hart_id, dbg_inst_fetch_req, dbg_inst_fetch_ack, dbg_reg_wren,
           dbg_inst_fetch_addr, dbg_inst_fetch_rddata, dbg_reg_wraddr, dbg_reg_wrdata,
           overflow, drop_cnt
  );

endinterface

// File: rtl/dbg_trace_fifo.sv
// Per-hart synchronous FIFO of trace records (push/pop/full/empty).
// Latency: 1 cycle write-to-readable; read data is the current head (no fall-through).
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module dbg_trace_fifo
  import dbg_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       i_push,
  input  trace_rec_t i_dat,
  input  logic       i_pop,
  output trace_rec_t o_dat,
  output logic       o_full,
  output logic       o_empty
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit: equal = empty, only MSB differs = full.
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  trace_rec_t  r_mem [DEPTH];
  logic        w_do_push;
  logic        w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, the slot being written is the head being popped this same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_dat     = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_do_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/dbg_trace_arbiter.sv
// Serialises per-hart trace records onto one dbg_* port via round-robin over per-hart FIFOs.
// Latency: 2 cycles input-to-output (FIFO write, then output register load); 1 record/cycle.
// Backpressure: out_ready low holds dbg_* stable and pops nothing; full FIFOs drop and count.
// Ports: clock, reset_n (async active-low); bus = slave side of dbg_trace_arbiter_if.
module dbg_trace_arbiter
  import dbg_trace_pkg::*;
#(
  parameter int NUM_HARTS  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  dbg_trace_arbiter_if.slave   bus
);
  trace_rec_t           w_fifo_dat [MAX_HARTS];
  logic                 w_full     [MAX_HARTS];
  logic                 w_empty    [MAX_HARTS];
  logic [MAX_HARTS-1:0] w_pop;
  logic                 w_load;
  logic                 w_found;
  logic [HART_ID_W-1:0] w_win;
  logic [HART_ID_W-1:0] w_idx;

  logic                 r_dbg_valid;
  trace_rec_t           r_dbg_rec;
  logic [HART_ID_W-1:0] r_dbg_hart;
  logic [HART_ID_W-1:0] r_rr_last;

  for (genvar h = 0; h < MAX_HARTS; h++) begin : g_hart
    if (h < NUM_HARTS) begin : g_used
      trace_rec_t            w_in_rec;
      logic                  w_drop;
      logic                  r_overflow;
      logic [DROP_CNT_W-1:0] r_drop_cnt;

      assign w_in_rec = '{
        fetch_req:    bus.in_fetch_req[h],
        fetch_addr:   bus.in_fetch_addr[h*32 +: 32],
        fetch_ack:    bus.in_fetch_ack[h],
        fetch_rddata: bus.in_fetch_rddata[h*32 +: 32],
        reg_wren:     bus.in_reg_wren[h],
        reg_wraddr:   bus.in_reg_wraddr[h*5 +: 5],
        reg_wrdata:   bus.in_reg_wrdata[h*64 +: 64]
      };

      dbg_trace_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .i_push  (bus.in_valid[h]),
        .i_dat   (w_in_rec),
        .i_pop   (w_pop[h]),
        .o_dat   (w_fifo_dat[h]),
        .o_full  (w_full[h]),
        .o_empty (w_empty[h])
      );

      // A pop in the same cycle frees the slot, so only full-without-pop drops.
      assign w_drop = bus.in_valid[h] & w_full[h] & ~w_pop[h];

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_overflow <= 1'b0;
          r_drop_cnt <= '0;
        end else if (w_drop) begin
          r_overflow <= 1'b1;
          if (r_drop_cnt != {DROP_CNT_W{1'b1}}) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
        end
      end

      assign bus.overflow[h]                          = r_overflow;
      assign bus.drop_cnt[h*DROP_CNT_W +: DROP_CNT_W] = r_drop_cnt;
    end else begin : g_unused
      // Absent harts look permanently empty so the arbiter skips their slots.
      assign w_fifo_dat[h] = '0;
      assign w_full[h]     = 1'b0;
      assign w_empty[h]    = 1'b1;
    end
  end

  // Output register accepts a new record when empty or when its record is taken.
  assign w_load = ~r_dbg_valid | bus.out_ready;

  // First non-empty slot after r_rr_last; the 2-bit index wraps over all four slots.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 1; k <= MAX_HARTS; k++) begin
      w_idx = r_rr_last + HART_ID_W'(k);
      if (!w_found && !w_empty[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_load && w_found) w_pop[w_win] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_dbg_valid <= 1'b0;
      r_dbg_rec   <= '0;
      r_dbg_hart  <= '0;
      r_rr_last   <= HART_ID_W'(NUM_HARTS - 1);
    end else if (w_load) begin
      r_dbg_valid <= w_found;
      if (w_found) begin
        r_dbg_rec  <= w_fifo_dat[w_win];
        r_dbg_hart <= w_win;
        r_rr_last  <= w_win;
      end
    end
  end

  assign bus.dbg_valid             = r_dbg_valid;
  assign bus.dbg_hart_id           = r_dbg_hart;
  assign bus.dbg_inst_fetch_req    = r_dbg_rec.fetch_req;
  assign bus.dbg_inst_fetch_addr   = r_dbg_rec.fetch_addr;
  assign bus.dbg_inst_fetch_ack    = r_dbg_rec.fetch_ack;
  assign bus.dbg_inst_fetch_rddata = r_dbg_rec.fetch_rddata;
  assign bus.dbg_reg_wren          = r_dbg_rec.reg_wren;
  assign bus.dbg_reg_wraddr        = r_dbg_rec.reg_wraddr;
  assign bus.dbg_reg_wrdata        = r_dbg_rec.reg_wrdata;

endmodule

// File: tb/tb_dbg_trace_arbiter.sv
// Self-checking bench for dbg_trace_arbiter: latency vectors, round-robin, overflow,
// back-pressure hold, full-FIFO push-with-pop and asynchronous reset mid-stream.
// Expected records are queued per hart at drive time and popped when the DUT emits them.
module tb_dbg_trace_arbiter;
  import dbg_trace_pkg::*;

  localparam int NH    = 4;
  localparam int DEPTH = 4;
  localparam int DW    = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dbg_trace_arbiter_if #(.NUM_HARTS(NH), .DROP_CNT_W(DW)) bus ();

  dbg_trace_arbiter #(.NUM_HARTS(NH), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0] hart;
    trace_rec_t rec;
    logic [1:0] exp_id;
    trace_rec_t exp_rec;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  trace_rec_t exp_q [NH][$];
  int         id_log[$];
  logic       prev_stall = 1'b0;
  trace_rec_t prev_rec;
  logic [1:0] prev_id;

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic trace_rec_t mk_rec(input logic req, input logic [31:0] a, input logic ack,
                                        input logic [31:0] rd, input logic wren,
                                        input logic [4:0] wa, input logic [63:0] wd);
    trace_rec_t r;
    r.fetch_req = req; r.fetch_addr = a; r.fetch_ack = ack; r.fetch_rddata = rd;
    r.reg_wren = wren; r.reg_wraddr = wa; r.reg_wrdata = wd;
    return r;
  endfunction

  function automatic trace_rec_t rand_rec();
    return mk_rec(1'($urandom), $urandom, 1'($urandom), $urandom, 1'($urandom),
                  5'($urandom), {$urandom, $urandom});
  endfunction

  function automatic trace_rec_t dbg_rec();
    return mk_rec(bus.dbg_inst_fetch_req, bus.dbg_inst_fetch_addr, bus.dbg_inst_fetch_ack,
                  bus.dbg_inst_fetch_rddata, bus.dbg_reg_wren, bus.dbg_reg_wraddr,
                  bus.dbg_reg_wrdata);
  endfunction

  function automatic int q_total();
    int n = 0;
    for (int h = 0; h < NH; h++) n += exp_q[h].size();
    return n;
  endfunction

  task automatic clear_in();
    bus.in_valid = '0; bus.in_fetch_req = '0; bus.in_fetch_ack = '0;
    bus.in_fetch_addr = '0; bus.in_fetch_rddata = '0; bus.in_reg_wren = '0;
    bus.in_reg_wraddr = '0; bus.in_reg_wrdata = '0;
  endtask

  // Present one record on hart h this cycle; queue it if it should be accepted.
  task automatic drive(input logic [1:0] h, input trace_rec_t r, input bit acc);
    int b;
    b = int'(h);
    bus.in_valid[b]                 = 1'b1;
    bus.in_fetch_req[b]             = r.fetch_req;
    bus.in_fetch_addr[b*32 +: 32]   = r.fetch_addr;
    bus.in_fetch_ack[b]             = r.fetch_ack;
    bus.in_fetch_rddata[b*32 +: 32] = r.fetch_rddata;
    bus.in_reg_wren[b]              = r.reg_wren;
    bus.in_reg_wraddr[b*5 +: 5]     = r.reg_wraddr;
    bus.in_reg_wrdata[b*64 +: 64]   = r.reg_wrdata;
    if (acc) exp_q[b].push_back(r);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    clear_in();
  endtask

  task automatic flush_sb();
    for (int h = 0; h < NH; h++) exp_q[h].delete();
    id_log.delete();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_in();
    bus.out_ready = 1'b1;
    flush_sb();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (q_total() != 0 && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({name, "_undrained"}, q_total(), 0);
    repeat (4) tick();
  endtask

  // Single record with exact 2-cycle latency and a one-cycle valid pulse.
  task automatic run_vec(input vec_t v, input string name);
    drive(v.hart, v.rec, 1'b1);
    @(negedge clock);
    check({name, "_t0_valid"}, bus.dbg_valid, 1'b0);
    tick();
    @(negedge clock);
    check({name, "_t1_valid"}, bus.dbg_valid, 1'b0);
    tick();
    @(negedge clock);
    check({name, "_t2_valid"}, bus.dbg_valid, 1'b1);
    check({name, "_t2_id"}, bus.dbg_hart_id, v.exp_id);
    check({name, "_t2_rec"}, dbg_rec(), v.exp_rec);
    tick();
    @(negedge clock);
    check({name, "_t3_valid"}, bus.dbg_valid, 1'b0);
    tick();
  endtask

  // Scoreboard consumer and hold-stability monitor.
  always @(negedge clock) begin
    trace_rec_t cur;
    trace_rec_t exp;
    logic [1:0] id;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = dbg_rec();
      id  = bus.dbg_hart_id;
      if (prev_stall) begin
        check("hold_valid", bus.dbg_valid, 1'b1);
        check("hold_id", id, prev_id);
        check("hold_rec", cur, prev_rec);
      end
      if (bus.dbg_valid && bus.out_ready) begin
        id_log.push_back(int'(id));
        if (exp_q[id].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rec: hart %0d emitted %h, required nothing", id, cur);
        end else begin
          exp = exp_q[id].pop_front();
          check("out_rec", cur, exp);
        end
      end
      prev_stall = bus.dbg_valid && !bus.out_ready;
      prev_rec   = cur;
      prev_id    = id;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [5];
    logic [7:0] acc_mask [NH];
    trace_rec_t r;

    vecs[0] = '{hart: 2'd2,
                rec:     mk_rec(1'b1, 32'h8000_0010, 1'b1, 32'h0000_0013, 1'b1, 5'd5, 64'hDEAD_BEEF),
                exp_id:  2'd2,
                exp_rec: mk_rec(1'b1, 32'h8000_0010, 1'b1, 32'h0000_0013, 1'b1, 5'd5, 64'hDEAD_BEEF)};
    vecs[1] = '{hart: 2'd0,
                rec:     mk_rec(1'b1, '1, 1'b1, '1, 1'b1, 5'h1F, '1),
                exp_id:  2'd0,
                exp_rec: mk_rec(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF)};
    vecs[2] = '{hart: 2'd1,
                rec:     mk_rec(1'b0, 32'hA5A5_5A5A, 1'b1, 32'h1234_5678, 1'b0, 5'd10, 64'h0123_4567_89AB_CDEF),
                exp_id:  2'd1,
                exp_rec: mk_rec(1'b0, 32'hA5A5_5A5A, 1'b1, 32'h1234_5678, 1'b0, 5'd10, 64'h0123_4567_89AB_CDEF)};
    vecs[3] = '{hart: 2'd3,
                rec:     mk_rec(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b1, 5'd1, 64'h8000_0000_0000_0001),
                exp_id:  2'd3,
                exp_rec: mk_rec(1'b1, 32'h0000_0004, 1'b0, 32'h0, 1'b1, 5'd1, 64'h8000_0000_0000_0001)};
    vecs[4] = '{hart: 2'd3,
                rec:     mk_rec(1'b1, 32'hC0DE_0000, 1'b1, 32'hFEED_F00D, 1'b1, 5'd7, 64'h5555_AAAA_5555_AAAA),
                exp_id:  2'd3,
                exp_rec: mk_rec(1'b1, 32'hC0DE_0000, 1'b1, 32'hFEED_F00D, 1'b1, 5'd7, 64'h5555_AAAA_5555_AAAA)};

    // Accepted pushes per cycle when all harts push for 8 cycles (bit c = cycle c).
    acc_mask[0] = 8'h3F;
    acc_mask[1] = 8'h5F;
    acc_mask[2] = 8'h9F;
    acc_mask[3] = 8'h1F;

    clear_in();
    bus.out_ready = 1'b1;
    do_reset();

    // Reset state
    @(negedge clock);
    check("rst_valid", bus.dbg_valid, 1'b0);
    check("rst_id", bus.dbg_hart_id, 2'd0);
    check("rst_rec", dbg_rec(), 136'd0);
    check("rst_overflow", bus.overflow, 4'd0);
    check("rst_drop_cnt", bus.drop_cnt, 64'd0);
    tick();

    // Single-record latency vectors
    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    wait_drain("vec");

    // All harts push every cycle for 8 cycles
    do_reset();
    for (int c = 0; c < 8; c++) begin
      for (int h = 0; h < NH; h++) drive(2'(h), rand_rec(), acc_mask[h][c]);
      tick();
    end
    @(negedge clock);
    check("rr_drop_cnt", bus.drop_cnt, {16'd3, 16'd2, 16'd2, 16'd2});
    check("rr_overflow", bus.overflow, 4'hF);
    wait_drain("rr");
    check("rr_count", id_log.size(), 23);
    for (int i = 0; i < 8 && i < id_log.size(); i++)
      check($sformatf("rr_id%0d", i), id_log[i], i % 4);

    // Overflow on hart 1 behind a stalled output
    do_reset();
    bus.out_ready = 1'b0;
    drive(2'd0, rand_rec(), 1'b1);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(2'd1, rand_rec(), i < 4);
      if (i == 5) begin
        @(negedge clock);
        check("ovf_cnt_after_first_drop", bus.drop_cnt[16 +: 16], 16'd1);
        check("ovf_flag_after_first_drop", bus.overflow, 4'b0010);
      end
      tick();
    end
    @(negedge clock);
    check("ovf_drop_cnt", bus.drop_cnt, {16'd0, 16'd0, 16'd2, 16'd0});
    check("ovf_flag", bus.overflow, 4'b0010);
    @(posedge clock);
    #1;
    bus.out_ready = 1'b1;
    wait_drain("ovf");
    check("ovf_count", id_log.size(), 5);

    // Back-pressure: out_ready 1,0,0,1 while hart 2 streams
    do_reset();
    drive(2'd2, rand_rec(), 1'b1);
    tick();
    drive(2'd2, rand_rec(), 1'b1);
    tick();
    drive(2'd2, rand_rec(), 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tick();
    @(negedge clock);
    check("bp_stalled_valid", bus.dbg_valid, 1'b1);
    check("bp_stalled_id", bus.dbg_hart_id, 2'd2);
    tick();
    bus.out_ready = 1'b1;
    wait_drain("bp");
    check("bp_count", id_log.size(), 3);

    // Full FIFO on hart 3 pushed in the same cycle as it is popped
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(2'd3, rand_rec(), 1'b1);
      tick();
    end
    bus.out_ready = 1'b1;
    drive(2'd3, rand_rec(), 1'b1);
    tick();
    @(negedge clock);
    check("fullpop_drop_cnt", bus.drop_cnt, 64'd0);
    check("fullpop_overflow", bus.overflow, 4'd0);
    wait_drain("fullpop");
    check("fullpop_count", id_log.size(), 6);

    // Asynchronous reset with records buffered
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      r = rand_rec();
      drive(2'd0, r, 1'b1);
      tick();
    end
    tick();
    @(negedge clock);
    check("mid_rst_pre_valid", bus.dbg_valid, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_async_valid", bus.dbg_valid, 1'b0);
    check("mid_rst_async_rec", dbg_rec(), 136'd0);
    flush_sb();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    run_vec(vecs[4], "post_rst");
    wait_drain("post_rst");
    check("post_rst_count", id_log.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbg_trace_arbiter.md
# dbg_trace_arbiter

Collects per-hart debug trace records (instruction fetch and register writeback events) from up to four cores and serialises them onto the single `dbg_*` trace port consumed by the simulation monitor. Each hart has its own small FIFO. A round-robin arbiter drains the FIFOs into a registered output stage, one record per cycle, tagged with `dbg_hart_id`. Records that arrive while a hart's FIFO is full are dropped and counted.

## Interface
Parameters:
- `NUM_HARTS`, 4 — number of hart inputs, legal 1..4
- `FIFO_DEPTH`, 4 — entries per hart FIFO, power of two, ≥2
- `DROP_CNT_W`, 16 — width of each per-hart drop counter

Ports (per-hart buses are packed; hart h occupies slice `[h*W +: W]`):
- `clock`  in  1  sole clock
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  NUM_HARTS  record present this cycle
- `in_fetch_req` / `in_fetch_ack`  in  NUM_HARTS each  fetch request / ack flags
- `in_fetch_addr` / `in_fetch_rddata`  in  NUM_HARTS*32 each
- `in_reg_wren`  in  NUM_HARTS
- `in_reg_wraddr`  in  NUM_HARTS*5
- `in_reg_wrdata`  in  NUM_HARTS*64
- `out_ready`  in  1  sink accepts record; tied to 1 for the monitor
- `dbg_valid`  out  1  record on output
- `dbg_hart_id`  out  2  source hart
- `dbg_inst_fetch_req`, `dbg_inst_fetch_ack`, `dbg_reg_wren`  out  1 each
- `dbg_inst_fetch_addr`, `dbg_inst_fetch_rddata`  out  32 each
- `dbg_reg_wraddr`  out  5
- `dbg_reg_wrdata`  out  64
- `overflow`  out  NUM_HARTS  sticky per-hart drop flag
- `drop_cnt`  out  NUM_HARTS*DROP_CNT_W  per-hart dropped-record count

## Operation
- **Push:** when `in_valid[h]` is high, the 136-bit record for hart h is written into FIFO h, unless that FIFO is full.
- **Full FIFO:** if FIFO h is full and not popped this cycle, the incoming record is dropped.
  - `overflow[h]` is set and stays set until reset.
  - `drop_cnt[h]` increments and saturates at all-ones.
- **Full FIFO, simultaneous pop:** if FIFO h is full and is popped this cycle, the push is accepted.
- **Output stage:** one register holding a record plus `dbg_valid`. It loads when empty, or when `dbg_valid & out_ready`, so there is no bubble under back-pressure release.
- **Arbitration:** round-robin with a last-grant pointer `rr_last`.
  - The winner is the first non-empty FIFO after `rr_last`, in wrapping order.
  - `rr_last` updates only when a record is actually loaded.
  - If no FIFO is non-empty, the output stage empties (`dbg_valid`=0) when the current record is consumed.
- **Hold:** while `dbg_valid & !out_ready`, all `dbg_*` outputs are held stable and no FIFO is popped.
- **Hart ID:** `dbg_hart_id` is the winning index zero-extended to 2 bits.
- **Unused harts:** inputs for harts ≥ `NUM_HARTS` do not exist; those arbiter slots are skipped.
- **Reset:**
  - FIFOs are emptied.
  - `rr_last` = `NUM_HARTS-1`, so hart 0 wins first.
  - All `dbg_*` outputs, `overflow`, and `drop_cnt` are 0.
  - Reset mid-transfer discards all buffered records with no partial output.

## Timing
- A record presented in cycle t (FIFO empty, no contention) is written at the end of cycle t, loaded at the end of cycle t+1, and visible on `dbg_*` in cycle t+2. Latency is 2 cycles; there is no fall-through path.
- Throughput is 1 record/cycle aggregate with `out_ready`=1. Each hart gets at least 1 slot per `NUM_HARTS` cycles when all are busy.
- `overflow` and `drop_cnt` update at the end of the drop cycle and are visible in cycle t+1.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits. Full/empty is decided by MSB compare; pointers wrap naturally.
- All outputs are registered. No combinational path exists from any input to any output.

## Structure
- Package `dbg_trace_pkg` contains:
  - `trace_rec_t` packed struct: fetch_req, fetch_addr, fetch_ack, fetch_rddata, reg_wren, reg_wraddr, reg_wrdata (136 bits)
  - `HART_ID_W` = 2
  - `MAX_HARTS` = 4
- Sub-module `dbg_trace_fifo`: synchronous FIFO of `trace_rec_t` with push/pop/full/empty. It is instantiated `NUM_HARTS` times.
- The top level holds the arbiter, the output register and the drop counters.

## Test plan
- **Single record, hart 2:** `in_fetch_addr`=0x8000_0010, `reg_wraddr`=5, `reg_wrdata`=0xDEAD_BEEF → exactly one cycle of `dbg_valid` at t+2 with `dbg_hart_id`=2 and identical fields.
- **All 4 harts push every cycle for 8 cycles, `out_ready`=1:** output hart IDs run 0,1,2,3,0,1,…; per-hart order is preserved; no record is lost before the FIFOs fill.
- **Overflow on hart 1:** `out_ready`=0, hart 1 pushes 6 records (depth 4) → `overflow[1]`=1, `drop_cnt[1]`=2. After `out_ready`=1 the first 4 records emerge in order.
- **Back-pressure:** `out_ready` toggles 1,0,0,1 → outputs are stable across the stall and no duplicate or skipped record appears.
- **Full FIFO with simultaneous pop and push:** record is accepted and `drop_cnt` is unchanged.
- **Reset mid-stream:** `reset_n` is asserted with 3 records buffered → `dbg_valid`=0 immediately (asynchronous). After release, the first new record from hart 3 appears at t+2 and the stale records never appear.
